// File: rtl/demux_vc_pkg.sv
// demux_vc_pkg: shared state encoding and parameter defaults for the VC demultiplexer.
// Rev 1.0
`default_nettype none

package demux_vc_pkg;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_NUM_VC = 2;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [0:0] {
    PASS  = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/demux_vc_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; async active-low clear.
// Rev 1.0
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_vc.sv
// demux_vc: routes words to NUM_VC lanes by their top selector bits, with one-word hold on backpressure.
// Rev 1.0
`default_nettype none

module demux_vc
  import demux_vc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_VC = DEF_NUM_VC,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  input  logic [NUM_VC-1:0]        vc_almost_full,
  output logic                     ready_out,
  output logic [NUM_VC*DATA_W-1:0] data_out,
  output logic [NUM_VC-1:0]        push,
  output logic                     err_bad_vc,
  output logic [NUM_VC*CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int SEL_W = ($clog2(NUM_VC) > 1) ? $clog2(NUM_VC) : 1;
  localparam logic [SEL_W:0] C_NUM_VC = (SEL_W+1)'(NUM_VC);

  state_t              state;
  logic [DATA_W-1:0]   hold;

  logic [SEL_W-1:0]    sel_in;
  logic [SEL_W-1:0]    sel_hold;
  logic                bad_in;
  logic [NUM_VC-1:0]   oh_in;
  logic [NUM_VC-1:0]   oh_hold;
  logic                af_in;
  logic                af_hold;
  logic [NUM_VC-1:0]   push_sel;
  logic [DATA_W-1:0]   push_word;
  logic                drop;

  assign sel_in    = data_in[DATA_W-1 -: SEL_W];
  assign sel_hold  = hold[DATA_W-1 -: SEL_W];
  assign bad_in    = ({1'b0, sel_in} >= C_NUM_VC);
  assign ready_out = (state == PASS);

  always_comb begin
    oh_in   = '0;
    oh_hold = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      oh_in[i]   = (sel_in == SEL_W'(i));
      oh_hold[i] = (sel_hold == SEL_W'(i));
    end
  end

  assign af_in   = |(oh_in & vc_almost_full);
  assign af_hold = |(oh_hold & vc_almost_full);

  // A draining held word takes priority; data_in is ignored because ready_out is low in STALL.
  always_comb begin
    push_sel  = '0;
    push_word = hold;
    drop      = 1'b0;
    if (state == STALL) begin
      if (!af_hold) begin
        push_sel = oh_hold;
      end
    end else if (valid_in) begin
      if (bad_in) begin
        drop = 1'b1;
      end else if (!af_in) begin
        push_sel  = oh_in;
        push_word = data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PASS;
      hold       <= '0;
      data_out   <= '0;
      push       <= '0;
      err_bad_vc <= 1'b0;
    end else begin
      push       <= push_sel;
      err_bad_vc <= drop;
      for (int i = 0; i < NUM_VC; i++) begin
        data_out[i*DATA_W +: DATA_W] <= push_sel[i] ? push_word : '0;
      end
      case (state)
        PASS: begin
          if (valid_in && !bad_in && af_in) begin
            hold  <= data_in;
            state <= STALL;
          end
        end
        STALL: begin
          if (!af_hold) begin
            hold  <= '0;
            state <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_lane_cnt
    sat_counter #(.WIDTH(CNT_W)) u_pkt_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (push_sel[g]),
      .count (pkt_cnt[g*CNT_W +: CNT_W])
    );
  end

  sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop),
    .count (drop_cnt)
  );

endmodule

`default_nettype wire
